param_stack_unit: RTL and testbench

//  Parametrised data-stack engine for the stack processor. Replaces the fixed
//  16-bit top/second register pair with a WIDTH x DEPTH stack. Top two entries
//  are cached in registers and the rest sit in a spill array.

---
 rtl/stack_pkg.sv | 38 +++
 rtl/stack_spill_ram.sv | 24 ++
 rtl/param_stack_unit.sv | 141 ++++++++++++++
 tb/tb_param_stack_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared stack op codes and default sizes for the data-stack engine,
// its control unit and its bench.
package stack_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 64;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_OVER = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_REP1 = 3'd6;
  localparam logic [2:0] OP_REP2 = 3'd7;

  function automatic logic is_push_op(
    input logic [2:0] o
  );
    return (o == OP_PUSH) || (o == OP_DUP) ||
           (o == OP_OVER);
  endfunction

  function automatic logic needs_one(
    input logic [2:0] o
  );
    return (o == OP_DROP) || (o == OP_DUP) ||
           (o == OP_REP1);
  endfunction

  function automatic logic needs_two(
    input logic [2:0] o
  );
    return (o == OP_OVER) || (o == OP_SWAP) ||
           (o == OP_REP2);
  endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage for stack entries below top/second.
// One synchronous write port, one combinational read port.
module stack_spill_ram #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 62,
  parameter int AW      = 6
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack_unit.sv
// WIDTH x DEPTH data stack: top/second cached in flops,
// deeper entries in a spill RAM. One op per cycle.
module param_stack_unit
  import stack_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             op_err,
  output logic             ovf,
  output logic             unf
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW =
    (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [WIDTH-1:0] top_q, sec_q;
  logic [WIDTH-1:0] top_d, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, ovf_q, unf_q;
  logic             ge1, ge2, ge3, is_full;
  logic             push_op;
  logic             ovf_v, unf_v, viol, do_op;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rd_data, spill, pval;

  assign ge1     = cnt_q >= CNT_W'(1);
  assign ge2     = cnt_q >= CNT_W'(2);
  assign ge3     = cnt_q >= CNT_W'(3);
  assign is_full = cnt_q == CNT_W'(DEPTH);
  assign push_op = is_push_op(op);

  assign ovf_v = op_valid & push_op & is_full;
  assign unf_v = op_valid &
                 ((needs_one(op) & ~ge1) |
                  (needs_two(op) & ~ge2));
  assign viol  = ovf_v | unf_v;
  assign do_op = op_valid & ~viol;

  // Spill slot below second is count-3; the slot
  // that second lands in on a push is count-2.
  assign waddr = AW'(cnt_q - CNT_W'(2));
  assign raddr = AW'(cnt_q - CNT_W'(3));
  assign we    = do_op & push_op & ge2;
  assign spill = ge3 ? rd_data : '0;

  stack_spill_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_spill (
    .CLK   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (sec_q),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_comb begin
    pval = push_data;
    if (op == OP_DUP)  pval = top_q;
    if (op == OP_OVER) pval = sec_q;
  end

  always_comb begin
    top_d = top_q;
    sec_d = sec_q;
    cnt_d = cnt_q;
    if (do_op) begin
      case (op)
        OP_PUSH, OP_DUP, OP_OVER: begin
          top_d = pval;
          sec_d = top_q;
          cnt_d = cnt_q + CNT_W'(1);
        end
        OP_DROP: begin
          top_d = sec_q;
          sec_d = spill;
          cnt_d = cnt_q - CNT_W'(1);
        end
        OP_SWAP: begin
          top_d = sec_q;
          sec_d = top_q;
        end
        OP_REP1: begin
          top_d = push_data;
        end
        OP_REP2: begin
          top_d = push_data;
          sec_d = spill;
          cnt_d = cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      top_q <= '0;
      sec_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      sec_q <= sec_d;
      cnt_q <= cnt_d;
      err_q <= viol;
      // A fresh violation beats a same-cycle clear.
      ovf_q <= ovf_v | (ovf_q & ~clr_err);
      unf_q <= unf_v | (unf_q & ~clr_err);
    end
  end

  assign top    = top_q;
  assign second = sec_q;
  assign count  = cnt_q;
  assign full   = is_full;
  assign empty  = cnt_q == '0;
  assign op_err = err_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

// File: tb/tb_param_stack_unit.sv
// Bench for param_stack_unit: queue-based stack model
// checked every cycle plus hand-computed spot checks.
module tb_param_stack_unit;
  import stack_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset, op_valid, clr_err;
  logic [2:0]  op;
  logic [15:0] push_data;
  logic [15:0] top, second;
  logic [2:0]  count;
  logic        full, empty, op_err, ovf, unf;

  logic        r64, v64, clr64;
  logic [2:0]  op64;
  logic [15:0] d64;
  logic [15:0] top64, sec64;
  logic [6:0]  cnt64;
  logic        full64, empty64, err64;
  logic        ovf64, unf64;

  param_stack_unit #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK), .reset(reset),
    .op_valid(op_valid), .op(op),
    .push_data(push_data), .clr_err(clr_err),
    .top(top), .second(second), .count(count),
    .full(full), .empty(empty), .op_err(op_err),
    .ovf(ovf), .unf(unf)
  );

  param_stack_unit #(.WIDTH(16), .DEPTH(64)) dut64 (
    .CLK(CLK), .reset(r64),
    .op_valid(v64), .op(op64),
    .push_data(d64), .clr_err(clr64),
    .top(top64), .second(sec64), .count(cnt64),
    .full(full64), .empty(empty64), .op_err(err64),
    .ovf(ovf64), .unf(unf64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Stack model: q[$] is the top, q[0] the bottom.
  int q[$];
  bit m_err, m_ovf, m_unf;
  bit chk_en = 1'b0;

  task automatic model_step(input logic v,
                            input logic [2:0] o,
                            input logic [15:0] d,
                            input logic c);
    int n;
    int t;
    bit ov;
    bit un;
    n  = q.size();
    ov = 1'b0;
    un = 1'b0;
    if (v) begin
      case (o)
        OP_PUSH: if (n == 4) ov = 1; else q.push_back(d);
        OP_DROP: if (n < 1) un = 1; else void'(q.pop_back());
        OP_DUP: begin
          if (n < 1) un = 1;
          else if (n == 4) ov = 1;
          else q.push_back(q[n-1]);
        end
        OP_OVER: begin
          if (n < 2) un = 1;
          else if (n == 4) ov = 1;
          else q.push_back(q[n-2]);
        end
        OP_SWAP: begin
          if (n < 2) un = 1;
          else begin
            t = q[n-1];
            q[n-1] = q[n-2];
            q[n-2] = t;
          end
        end
        OP_REP1: if (n < 1) un = 1; else q[n-1] = d;
        OP_REP2: begin
          if (n < 2) un = 1;
          else begin
            void'(q.pop_back());
            q[n-2] = d;
          end
        end
        default: ;
      endcase
    end
    m_err = ov | un;
    m_ovf = ov | (m_ovf & !c);
    m_unf = un | (m_unf & !c);
  endtask

  always @(posedge CLK)
    if (reset) model_step(op_valid, op, push_data, clr_err);

  always @(negedge CLK) begin
    int n;
    if (chk_en) begin
      n = q.size();
      chk("top", top, n > 0 ? q[n-1] : 0);
      chk("second", second, n > 1 ? q[n-2] : 0);
      chk("count", count, n);
      chk("full", full, n == 4);
      chk("empty", empty, n == 0);
      chk("op_err", op_err, m_err);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #2;
    reset = 1'b0;
    op_valid = 1'b0;
    clr_err = 1'b0;
    q.delete();
    m_err = 0;
    m_ovf = 0;
    m_unf = 0;
    #1;
    chk("rst_top", top, 0);
    chk("rst_cnt", count, 0);
    @(posedge CLK);
    #2;
    reset = 1'b1;
  endtask

  task automatic step(input logic [2:0] o,
                      input logic [15:0] d,
                      input logic c);
    op_valid = 1'b1;
    op = o;
    push_data = d;
    clr_err = c;
    @(posedge CLK);
    #2;
    op_valid = 1'b0;
    op = OP_NOP;
    clr_err = 1'b0;
  endtask

  task automatic step64(input logic [2:0] o,
                        input logic [15:0] d);
    v64 = 1'b1;
    op64 = o;
    d64 = d;
    @(posedge CLK);
    #2;
    v64 = 1'b0;
    op64 = OP_NOP;
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0;
    op = OP_NOP;
    push_data = '0;
    clr_err = 1'b0;
    r64 = 1'b1;
    v64 = 1'b0;
    op64 = OP_NOP;
    d64 = '0;
    clr64 = 1'b0;
    #3;
    r64 = 1'b0;

    // 1: pushes then binary ALU replace
    do_reset();
    chk_en = 1'b1;
    step(OP_PUSH, 1, 0);
    step(OP_PUSH, 2, 0);
    step(OP_PUSH, 3, 0);
    chk("t1_top", top, 3);
    chk("t1_sec", second, 2);
    chk("t1_cnt", count, 3);
    step(OP_REP2, 5, 0);
    chk("t1_rep2_top", top, 5);
    chk("t1_rep2_sec", second, 1);
    chk("t1_rep2_cnt", count, 2);

    // 2: fill via OVER/DUP, then overflow
    do_reset();
    step(OP_PUSH, 1, 0);
    step(OP_PUSH, 2, 0);
    step(OP_OVER, 0, 0);
    step(OP_DUP, 0, 0);
    chk("t2_top", top, 1);
    chk("t2_sec", second, 1);
    chk("t2_full", full, 1);
    step(OP_PUSH, 9, 0);
    chk("t2_err", op_err, 1);
    chk("t2_ovf", ovf, 1);
    chk("t2_top_kept", top, 1);
    chk("t2_cnt_kept", count, 4);
    step(OP_NOP, 0, 0);
    chk("t2_err_pulse", op_err, 0);
    chk("t2_ovf_sticky", ovf, 1);

    // 3: underflow, clear, clear vs new violation
    do_reset();
    step(OP_DROP, 0, 0);
    chk("t3_err", op_err, 1);
    chk("t3_unf", unf, 1);
    chk("t3_top", top, 0);
    step(OP_NOP, 0, 1);
    chk("t3_clr", unf, 0);
    step(OP_PUSH, 7, 0);
    step(OP_SWAP, 0, 0);
    chk("t3_unf2", unf, 1);
    chk("t3_top2", top, 7);
    chk("t3_cnt2", count, 1);
    step(OP_SWAP, 0, 1);
    chk("t3_clr_lose", unf, 1);
    step(OP_REP1, 16'hbeef, 0);
    chk("t3_rep1", top, 16'hbeef);

    // 4: swap then drop pulls from spill
    do_reset();
    step(OP_PUSH, 1, 0);
    step(OP_PUSH, 2, 0);
    step(OP_PUSH, 3, 0);
    step(OP_SWAP, 0, 0);
    chk("t4_swap_top", top, 2);
    chk("t4_swap_sec", second, 3);
    step(OP_DROP, 0, 0);
    chk("t4_top", top, 3);
    chk("t4_sec", second, 1);
    chk("t4_cnt", count, 2);

    // 5: fill to 4 and drain
    do_reset();
    for (int i = 1; i <= 4; i++) step(OP_PUSH, 16'(i), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_top", top, 4 - i);
      step(OP_DROP, 0, 0);
    end
    chk("t5_cnt", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_sec", second, 0);

    // 6: DEPTH=64 instance
    @(posedge CLK);
    #2;
    r64 = 1'b1;
    for (int i = 0; i < 40; i++) step64(OP_PUSH, 16'(i));
    chk("t6_mid_top", top64, 39);
    chk("t6_mid_cnt", cnt64, 40);
    v64 = 1'b1;
    op64 = OP_PUSH;
    d64 = 16'd40;
    #1;
    r64 = 1'b0;
    #1;
    chk("t6_async_top", top64, 0);
    chk("t6_async_sec", sec64, 0);
    chk("t6_async_cnt", cnt64, 0);
    chk("t6_async_flags",
        {err64, ovf64, unf64}, 0);
    @(posedge CLK);
    #2;
    v64 = 1'b0;
    r64 = 1'b1;
    chk("t6_discard", cnt64, 0);
    step64(OP_PUSH, 5);
    chk("t6_top5", top64, 5);
    chk("t6_cnt1", cnt64, 1);
    chk("t6_sec0", sec64, 0);
    for (int i = 1; i < 64; i++) step64(OP_PUSH, 16'(i + 100));
    chk("t6_full", full64, 1);
    chk("t6_full_top", top64, 163);
    step64(OP_PUSH, 1);
    chk("t6_ovf", ovf64, 1);
    step64(OP_DROP, 0);
    chk("t6_drop_top", top64, 162);
    chk("t6_drop_sec", sec64, 161);
    chk("t6_drop_cnt", cnt64, 63);

    @(posedge CLK);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
